// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - SPI master control and pin bundle
// Purpose: groups the local control handshake and the off-chip SPI pins of spi_master.
// Signals:
//   start              transfer request from local logic
//   slaveSelect        target slave index, N_SLAVES means "no slave"
//   masterDataToSend   byte to transmit
//   masterDataReceived last byte received
//   SCLK, CS, MOSI     SPI pins driven by the master
//   MISO               SPI pin driven by the selected slave
// Modports: master (spi_master side), slave (local logic / SPI slave side).
interface spi_master_if #(
    parameter int DATA_W   = 8,
    parameter int N_SLAVES = 3
);
    localparam int SEL_W = $clog2(N_SLAVES + 1);

    logic                start;
    logic [SEL_W-1:0]    slaveSelect;
    logic [DATA_W-1:0]   masterDataToSend;
    logic [DATA_W-1:0]   masterDataReceived;
    logic                SCLK;
    logic [0:N_SLAVES-1] CS;
    logic                MOSI;
    logic                MISO;

    modport master (
        input  start, slaveSelect, masterDataToSend, MISO,
        output masterDataReceived, SCLK, CS, MOSI
    );

    modport slave (
        output start, slaveSelect, masterDataToSend, MISO,
        input  masterDataReceived, SCLK, CS, MOSI
    );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 LSB-first SPI byte master for up to N_SLAVES slaves
// Purpose: one full-duplex byte exchange per accepted start request.
// Ports:
//   clk    system clock, SCLK is a gated copy of it
//   reset  asynchronous active-low reset
//   bus    spi_master_if.master: start/slaveSelect/masterDataToSend in,
//          masterDataReceived out, SCLK/CS/MOSI out, MISO in
module spi_master #(
    parameter int DATA_W   = 8,
    parameter int N_SLAVES = 3
) (
    input  logic               clk,
    input  logic               reset,
    spi_master_if.master       bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam int SEL_W = $clog2(N_SLAVES + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [0:N_SLAVES-1] cs_q, cs_d;
    logic [0:N_SLAVES-1] cs_sel;
    logic [CNT_W-1:0]    ptr_q;
    logic                sclk_en_q, sclk_en_d;
    logic                mosi;
    logic                accept;
    logic                last_bit;

    assign accept   = (state_q == IDLE) && bus.start && (int'(bus.slaveSelect) < N_SLAVES);
    assign last_bit = (state_q == XFER) && (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        for (int i = 0; i < N_SLAVES; i++) begin
            cs_sel[i] = (bus.slaveSelect != SEL_W'(i));
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = XFER;
            XFER:    if (last_bit)   state_d = DONE;
            DONE:    if (!bus.start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: MOSI follows the bit pointer advanced on falling edges, so it is
    // already settled before every SCLK rising edge. The gate enable is only
    // registered on falling clk edges, keeping SCLK glitch-free.
    always_comb begin
        mosi      = 1'b0;
        sclk_en_d = 1'b0;
        if (state_q == XFER) begin
            mosi      = tx_q[ptr_q];
            sclk_en_d = 1'b1;
        end
    end

    // Datapath next-state
    always_comb begin
        tx_d      = tx_q;
        rx_sr_d   = rx_sr_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        if (accept) begin
            tx_d  = bus.masterDataToSend;
            cnt_d = '0;
            cs_d  = cs_sel;
        end else if (state_q == XFER) begin
            rx_sr_d = {bus.MISO, rx_sr_q[DATA_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_bit) begin
                rx_data_d = {bus.MISO, rx_sr_q[DATA_W-1:1]};
                cs_d      = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
            cs_q      <= '1;
        end else begin
            tx_q      <= tx_d;
            rx_sr_q   <= rx_sr_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            cs_q      <= cs_d;
        end
    end

    // Falling-edge domain: SCLK gate and MOSI bit pointer. Outside XFER the
    // pointer parks at 0 so bit 0 is presented as soon as XFER is entered.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            sclk_en_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            sclk_en_q <= sclk_en_d;
            ptr_q     <= (state_q == XFER) ? cnt_q : '0;
        end
    end

    assign bus.SCLK               = clk & sclk_en_q;
    assign bus.MOSI               = mosi;
    assign bus.CS                 = cs_q;
    assign bus.masterDataReceived = rx_data_q;
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master
module tb_spi_master;
    logic clk = 1'b0;
    logic reset;

    spi_master_if bus ();

    spi_master dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    logic [7:0] last_rx = 8'h00;

    always @(posedge bus.SCLK) pulse_cnt++;

    function automatic logic [0:2] exp_cs(input int sel);
        logic [0:2] c;
        c = 3'b111;
        if (sel < 3) c[sel] = 1'b0;
        return c;
    endfunction

    // One byte exchange with a behavioural slave: the slave presents MISO bit i
    // after the i-th falling edge and the bench records MOSI there as well.
    task automatic run_xfer(input int sel, input logic [7:0] tx, input logic [7:0] mi, input string tag);
        logic [7:0] seen;
        logic [0:2] cs_exp;
        logic       cs_ok;
        int         p0;
        cs_exp = exp_cs(sel);
        cs_ok  = 1'b1;
        seen   = 8'h00;
        @(negedge clk);
        bus.start            = 1'b1;
        bus.slaveSelect      = 2'(sel);
        bus.masterDataToSend = tx;
        bus.MISO             = mi[0];
        p0                   = pulse_cnt;
        @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.start            = 1'b0;
            bus.slaveSelect      = 2'($urandom);
            bus.masterDataToSend = 8'($urandom);
            bus.MISO             = mi[i];
            #1;
            seen[i] = bus.MOSI;
            if (bus.CS !== cs_exp) cs_ok = 1'b0;
        end
        @(posedge clk);
        #1;
        last_rx = mi;
        n_checks++;
        if (bus.masterDataReceived !== mi) begin
            n_fail++;
            $display("FAIL %s rx: got %b expected %b", tag, bus.masterDataReceived, mi);
        end
        n_checks++;
        if (seen !== tx) begin
            n_fail++;
            $display("FAIL %s mosi: got %b expected %b", tag, seen, tx);
        end
        n_checks++;
        if (!cs_ok) begin
            n_fail++;
            $display("FAIL %s cs_during: got deviation expected %b", tag, cs_exp);
        end
        n_checks++;
        if (pulse_cnt - p0 !== 8) begin
            n_fail++;
            $display("FAIL %s sclk_pulses: got %0d expected 8", tag, pulse_cnt - p0);
        end
        n_checks++;
        if (bus.CS !== 3'b111) begin
            n_fail++;
            $display("FAIL %s cs_after: got %b expected 111", tag, bus.CS);
        end
        @(posedge clk);
    endtask

    task automatic check_idle_outputs(input string tag, input logic [7:0] rx_exp);
        n_checks++;
        if (bus.CS !== 3'b111 || bus.SCLK !== 1'b0 || bus.MOSI !== 1'b0 || bus.masterDataReceived !== rx_exp) begin
            n_fail++;
            $display("FAIL %s: got CS=%b SCLK=%b MOSI=%b rx=%h expected CS=111 SCLK=0 MOSI=0 rx=%h",
                     tag, bus.CS, bus.SCLK, bus.MOSI, bus.masterDataReceived, rx_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.slaveSelect = 2'd3;
        bus.masterDataToSend = 8'h00;
        bus.MISO = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_initial", 8'h00);
        @(negedge clk);
        reset = 1'b1;
        run_xfer(2, 8'hC3, 8'hA5, "pre_abort");
        @(negedge clk);
        bus.start = 1'b1;
        bus.slaveSelect = 2'd0;
        bus.masterDataToSend = 8'hFF;
        bus.MISO = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        last_rx = 8'h00;
        check_idle_outputs("reset_abort", 8'h00);
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset_release", 8'h00);
    endtask

    task automatic test_spec_vectors();
        run_xfer(1, 8'b01010011, 8'b00001001, "vec2");
        run_xfer(1, 8'b00111100, 8'b10011000, "vec3");
        run_xfer(1, 8'b01010101, 8'hFF,       "vec4a");
        run_xfer(1, 8'b01011111, 8'b10011000, "vec4b");
    endtask

    task automatic test_hold_start();
        logic [7:0] tx, mi, seen;
        int p0;
        tx = 8'h96;
        mi = 8'h3C;
        seen = 8'h00;
        @(negedge clk);
        bus.start = 1'b1;
        bus.slaveSelect = 2'd0;
        bus.masterDataToSend = tx;
        bus.MISO = mi[0];
        p0 = pulse_cnt;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (j < 8) begin
                bus.MISO = mi[j];
                #1;
                seen[j] = bus.MOSI;
            end
        end
        #1;
        last_rx = mi;
        n_checks++;
        if (pulse_cnt - p0 !== 8) begin
            n_fail++;
            $display("FAIL hold_pulses: got %0d expected 8", pulse_cnt - p0);
        end
        n_checks++;
        if (bus.masterDataReceived !== mi || seen !== tx) begin
            n_fail++;
            $display("FAIL hold_data: got rx=%b mosi=%b expected rx=%b mosi=%b", bus.masterDataReceived, seen, mi, tx);
        end
        check_idle_outputs("hold_idle", mi);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        run_xfer(0, 8'h5A, 8'hE1, "hold_restart");
    endtask

    task automatic test_select();
        int p0;
        run_xfer(0, 8'h81, 8'h7E, "sel0");
        run_xfer(2, 8'h42, 8'h24, "sel2");
        @(negedge clk);
        bus.start = 1'b1;
        bus.slaveSelect = 2'd3;
        bus.masterDataToSend = 8'hAA;
        p0 = pulse_cnt;
        repeat (10) @(negedge clk);
        #1;
        n_checks++;
        if (pulse_cnt - p0 !== 0) begin
            n_fail++;
            $display("FAIL sel3_pulses: got %0d expected 0", pulse_cnt - p0);
        end
        check_idle_outputs("sel3_idle", last_rx);
        bus.start = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            run_xfer($urandom_range(0, 2), 8'($urandom), 8'($urandom), $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_hold_start();
        test_select();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
